// File: rtl/u21_cfg_seq_pkg.sv
// Shared constants, FSM state encoding and field-offset helper for the u21
// wiring-ROM configuration sequencer.
package u21_pkg;

   localparam int FUNC_W = 4;
   localparam int PIN_W  = 2;
   localparam int WIRE_W = 3;
   localparam int NPINS  = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      PRESENT = 2'd2
   } state_e;

   // Bit offset of a pin's wiring field inside the assembled word.
   function automatic int pin_offset(input int pin, input int wire_w);
      return pin * wire_w;
   endfunction

endpackage

// File: rtl/u21_cfg_seq_rr_arb.sv
// Round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping modulo NREQ. Outputs are all-zero when en is low.
module u21_rr_arb #(
   parameter  int NREQ  = 4,
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] idx
);

   logic found;
   int   cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int i = 0; i < NREQ; i++) begin
         cand = (int'(ptr) + i) % NREQ;
         if (en && !found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/u21_cfg_seq.sv
// Shares the u21 wiring ROM among NREQ slots: grants round-robin, walks the
// ROM pin by pin, delivers the tagged word. Optional one-entry result cache
// enabled by defining U21_CFG_CACHE_EN.
module u21_cfg_seq #(
   parameter  int NREQ   = 4,
   parameter  int NPINS  = u21_pkg::NPINS,
   parameter  int WIRE_W = u21_pkg::WIRE_W,
   localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int WORD_W = NPINS * WIRE_W
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NREQ-1:0]                     req_valid,
   input  logic [NREQ*u21_pkg::FUNC_W-1:0]     req_func,
   output logic [NREQ-1:0]                     req_ready,
   output logic [u21_pkg::FUNC_W-1:0]          rom_func,
   output logic [u21_pkg::PIN_W-1:0]           rom_pin,
   input  logic [WIRE_W-1:0]                   rom_wiring,
   output logic                                cfg_valid,
   input  logic                                cfg_ready,
   output logic [IDX_W-1:0]                    cfg_dest,
   output logic [u21_pkg::FUNC_W-1:0]          cfg_func,
   output logic [WORD_W-1:0]                   cfg_word,
   output logic                                busy
);

   import u21_pkg::*;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [PIN_W-1:0]    pin_q, pin_d;
   logic [FUNC_W-1:0]   func_q, func_d;
   logic [IDX_W-1:0]    dest_q, dest_d;
   logic [WORD_W-1:0]   word_q, word_d;

   logic [NREQ-1:0]     gnt;
   logic [IDX_W-1:0]    gnt_idx;
   logic [FUNC_W-1:0]   grant_func;
   logic                arb_en;
   logic                last_pin;
   logic                cache_hit;
   logic [WORD_W-1:0]   cache_word;

   // Grants are suppressed while reset is held so every output reads zero.
   assign arb_en = (state_q == IDLE) && rst_n;

   u21_rr_arb #(.NREQ(NREQ)) u_arb (
      .req (req_valid),
      .ptr (ptr_q),
      .en  (arb_en),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   assign grant_func = req_func[FUNC_W*int'(gnt_idx) +: FUNC_W];
   assign last_pin   = (int'(pin_q) == NPINS - 1);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      pin_d   = pin_q;
      func_d  = func_q;
      dest_d  = dest_q;
      word_d  = word_q;
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               func_d  = grant_func;
               dest_d  = gnt_idx;
               ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDX_W'(1);
               pin_d   = '0;
               state_d = cache_hit ? PRESENT : FETCH;
               if (cache_hit) word_d = cache_word;
            end
         end
         FETCH: begin
            word_d[pin_offset(int'(pin_q), WIRE_W) +: WIRE_W] = rom_wiring;
            pin_d = pin_q + PIN_W'(1);
            if (last_pin) begin
               pin_d   = '0;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (cfg_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         pin_q   <= '0;
         func_q  <= '0;
         dest_q  <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         pin_q   <= pin_d;
         func_q  <= func_d;
         dest_q  <= dest_d;
         word_q  <= word_d;
      end
   end

`ifdef U21_CFG_CACHE_EN
   logic                cache_v_q, cache_v_d;
   logic [FUNC_W-1:0]   cache_f_q, cache_f_d;
   logic [WORD_W-1:0]   cache_w_q, cache_w_d;

   // Refill with the complete word on the final fetch cycle.
   always_comb begin
      cache_v_d = cache_v_q;
      cache_f_d = cache_f_q;
      cache_w_d = cache_w_q;
      if (state_q == FETCH && last_pin) begin
         cache_v_d = 1'b1;
         cache_f_d = func_q;
         cache_w_d = word_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_v_q <= 1'b0;
         cache_f_q <= '0;
         cache_w_q <= '0;
      end else begin
         cache_v_q <= cache_v_d;
         cache_f_q <= cache_f_d;
         cache_w_q <= cache_w_d;
      end
   end

   assign cache_hit  = cache_v_q && (cache_f_q == grant_func);
   assign cache_word = cache_w_q;
`else
   assign cache_hit  = 1'b0;
   assign cache_word = '0;
`endif

   assign req_ready = gnt;
   assign rom_func  = func_q;
   assign rom_pin   = (state_q == FETCH) ? pin_q : '0;
   assign cfg_valid = (state_q == PRESENT);
   assign cfg_dest  = dest_q;
   assign cfg_func  = func_q;
   assign cfg_word  = word_q;
   assign busy      = (state_q != IDLE);

endmodule
